// File: rtl/dsm_decimator.sv
// dsm_decimator: 1-bit delta-sigma bitstream to signed PCM via 2nd-order CIC
// (R = 2**DECIM_LOG2, M = 1) followed by a scale/saturate output stage.
// Ports: clk, rst_n (async, active low), enb (bit-rate enable),
//   dsm_in (1 -> +1, 0 -> -1), dout (signed OUT_W), dout_valid (1-cycle strobe).
// Optional: DSM_DECIMATOR_ROUND_EN selects round-half-up before the shift.
module dsm_decimator #(
  parameter int DECIM_LOG2 = 6,
  parameter int OUT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enb,
  input  logic                    dsm_in,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid
);

  localparam int W  = 2*DECIM_LOG2 + 2;
  localparam int SH = 2*DECIM_LOG2 - (OUT_W - 1);

  localparam logic [DECIM_LOG2-1:0] LAST = '1;

  localparam logic signed [W:0] MAXV =
    (W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [W:0] MINV = ~MAXV;

`ifdef DSM_DECIMATOR_ROUND_EN
  // Half an output LSB; zero when SH = 0.
  localparam logic signed [W:0] RND =
    ((W+1)'(1) << SH) >>> 1;
`endif

  logic signed [W-1:0]     int1;
  logic signed [W-1:0]     int2;
  logic signed [W-1:0]     d1;
  logic signed [W-1:0]     d2;
  logic [DECIM_LOG2-1:0]   phase;
  logic [1:0]              warm;

  logic signed [W-1:0]     x;
  logic signed [W-1:0]     c1;
  logic signed [W-1:0]     c2;
  logic signed [W:0]       c2x;
  logic signed [W:0]       pre;
  logic signed [W:0]       shf;
  logic signed [OUT_W-1:0] sat_v;
  logic                    epoch_end;

  // +1 is 0..01, -1 is 1..11.
  always_comb begin
    x = {{(W-1){~dsm_in}}, 1'b1};
  end

  always_comb begin
    epoch_end = enb && (phase == LAST);
  end

  // Comb section, evaluated on the pre-update int2.
  always_comb begin
    c1  = int2 - d1;
    c2  = c1 - d2;
    c2x = {c2[W-1], c2};
`ifdef DSM_DECIMATOR_ROUND_EN
    pre = c2x + RND;
`else
    pre = c2x;
`endif
    shf = pre >>> SH;
  end

  // Full-scale +1 lands exactly one above MAXV.
  always_comb begin
    if (shf > MAXV) begin
      sat_v = MAXV[OUT_W-1:0];
    end else if (shf < MINV) begin
      sat_v = MINV[OUT_W-1:0];
    end else begin
      sat_v = shf[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int1  <= '0;
      int2  <= '0;
      phase <= '0;
    end else if (enb) begin
      int1  <= int1 + x;
      int2  <= int2 + int1;
      phase <= phase + DECIM_LOG2'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
    end else if (epoch_end) begin
      d1 <= int2;
      d2 <= c1;
    end
  end

  // The first two epochs carry the CIC start-up transient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (epoch_end) begin
        dout <= sat_v;
        if (warm == 2'd2) begin
          dout_valid <= 1'b1;
        end else begin
          warm <= warm + 2'd1;
        end
      end
    end
  end

endmodule

// File: doc/dsm_decimator.md
Name: dsm_decimator

Overview:
- Receive-side counterpart of the team's 1-bit delta-sigma DAC modulator: takes a 1-bit delta-sigma bitstream and recovers signed multi-bit PCM samples.
- Core is a 2nd-order CIC decimator (2 integrators, 2 combs, differential delay 1), followed by a scale/saturate stage.
- Used for loopback checking of the DAC and for front-ends with an external 1-bit modulator.

Parameters:
- DECIM_LOG2, 6, log2 of the decimation ratio R (R = 64 by default). Legal range: 2*DECIM_LOG2 >= OUT_W-1.
- OUT_W, 8, output sample width, signed two's complement.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enb  input  1  bit-rate enable; dsm_in is consumed only on cycles where enb=1.
- dsm_in  input  1  delta-sigma bitstream; 1 maps to +1, 0 maps to -1.
- dout  output  OUT_W  decimated signed sample.
- dout_valid  output  1  one-cycle strobe; dout is new on this cycle.

Behaviour:
- Reset (rst_n=0, async assert, sync-safe deassert):
  - Integrators, comb delay registers, phase counter and warm-up counter clear to 0.
  - dout=0, dout_valid=0.
  - Mid-operation reset discards the partial epoch; no strobe is issued for it.
- Internal width: W = 2*DECIM_LOG2+2 bits signed. Integrators wrap modulo 2^W; no saturation inside the CIC.
- Integrators (update only when enb=1):
  - x = dsm_in ? +1 : -1, sign-extended to W.
  - int1 <= int1 + x.
  - int2 <= int2 + int1, using the pre-update int1.
  - enb=0 holds every register.
- Phase counter:
  - DECIM_LOG2 bits; increments on enb=1 and wraps from R-1 to 0.
  - An epoch ends on an enb=1 cycle with count == R-1.
- At epoch end, same clock edge:
  - s = int2 (pre-update value).
  - c1 = s - d1; d1 <= s.
  - c2 = c1 - d2; d2 <= c1 (all modulo 2^W).
  - dout register loads sat(c2 >>> SH), where SH = 2*DECIM_LOG2-(OUT_W-1) and >>> is an arithmetic shift (truncation toward -inf).
  - sat clamps to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. The clamp is needed because full-scale +1 gives c2 = +R^2, which shifts to 2^(OUT_W-1).
- Warm-up:
  - A 2-bit counter suppresses dout_valid for the first two epochs after reset (CIC transient).
  - dout still updates during warm-up.
  - From the 3rd epoch on, dout_valid=1 for exactly the one cycle following each epoch-end edge, simultaneous with the new dout value.
- Timing and strobes:
  - Latency: dout_valid rises one clock after the edge that consumed the R-th bit of the epoch.
  - The output rate is exactly one strobe per R enb-qualified bits, independent of gaps in enb.
  - dout holds its value between strobes.
  - dout_valid is never asserted on two consecutive cycles unless R enb cycles separate them (impossible for R >= 4).
- Steady-state gain: mean(x)*R^2 before scaling. Ideal DC input m in [-1,1] yields dout ≈ m*2^(OUT_W-1), clamped.

Optional Feature:
- Macro DSM_DECIMATOR_ROUND_EN.
- Defined: round half-up before the shift, i.e. dout = sat((c2 + 2^(SH-1)) >>> SH). Skipped when SH=0.
- Undefined: plain arithmetic-shift truncation as above.
- Both builds share the same ports, latency and warm-up.

Test Plan:
- Reset then dsm_in=1, enb=1 continuously, defaults -> no strobe for epochs 1-2. Strobe at epoch 3 onward with dout=127 (saturated, c2=4096). Strobes spaced exactly 64 cycles.
- dsm_in=0 continuously -> from epoch 3 dout=-128 every strobe.
- Alternating 1,0,1,0 -> from epoch 3 dout=0 (c1=32 constant, c2=0).
- Repeating 1,1,1,0 (75% density) -> from epoch 3 dout=64 (c2=2048) in both builds.
- enb toggled 1,0,1,0 with all-ones data -> strobes spaced 128 cycles. Values identical to the continuous-enb run. Registers frozen on enb=0 cycles.
- Assert rst_n=0 mid-epoch at bit 30, release, then all-ones -> immediate dout=0 and dout_valid=0. No strobe until the 3rd full epoch after release, which gives 127.
